matrix_row_fetch: RTL and testbench

//  Streams rows of an int32 matrix (A or B operand) from the 64-bit accelerator memory port into
//  512-bit, 16-lane row vectors for the systolic array (upstream of systolic_array).

---
 rtl/acc_pkg.sv | 33 +++
 rtl/row_pack.sv | 77 +++++++
 rtl/matrix_row_fetch.sv | 207 ++++++++++++++++++++
 tb/tb_matrix_row_fetch.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/acc_pkg.sv
// ---------------------------------------------------------------------------
// acc_pkg
//   Shared constants and types for the accelerator operand-fetch path.
//   ELEM_W  : width of one matrix element (int32)
//   LANES   : number of lanes in a systolic-array row vector
//   BEAT_W  : width of one memory read beat
//   LEN_W   : width of the per-row element-count field (0..16)
//   fetch_state_t : matrix_row_fetch FSM encoding
//   beats_for()   : number of 64-bit beats covering a row given its word
//                   offset inside the first beat and its element count
// ---------------------------------------------------------------------------
package acc_pkg;

    localparam int ELEM_W = 32;
    localparam int LANES  = 16;
    localparam int BEAT_W = 64;
    localparam int LEN_W  = 5;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } fetch_state_t;

    // ceil((off + len) / 2): each beat carries two words.
    function automatic logic [LEN_W-1:0] beats_for(input logic off,
                                                   input logic [LEN_W-1:0] len);
        return LEN_W'(({{LEN_W{1'b0}}, off} + {1'b0, len} + (LEN_W+1)'(1)) >> 1);
    endfunction

endpackage

// File: rtl/row_pack.sv
// ---------------------------------------------------------------------------
// row_pack
//   Assembles 64-bit read beats into one row vector of N_LANES 32-bit lanes.
//   Words are written from lane 0 upward (low word of a beat first). When the
//   row starts on an odd word the low word of the first beat is discarded.
//   Words at or beyond the row length are dropped; untouched lanes stay zero.
//
//   Ports
//     clk, rst      : clock, synchronous active-high reset
//     i_clear       : start a new row (zero lanes, load offset and length)
//     i_off         : 1 = drop the low word of the first beat of this row
//     i_len         : elements in this row (already limited to N_LANES)
//     i_beat_valid  : i_beat carries read data this cycle
//     i_beat        : 64-bit read data
//     o_lanes       : assembled row, lane i at bits [32*i +: 32]
// ---------------------------------------------------------------------------
module row_pack
    import acc_pkg::*;
#(
    parameter int N_LANES = acc_pkg::LANES
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_clear,
    input  logic                        i_off,
    input  logic [LEN_W-1:0]            i_len,
    input  logic                        i_beat_valid,
    input  logic [BEAT_W-1:0]           i_beat,
    output logic [ELEM_W*N_LANES-1:0]   o_lanes
);

    logic [ELEM_W-1:0] r_lane [N_LANES];
    logic [LEN_W-1:0]  r_wptr;    // next lane to write (may run past r_len)
    logic [LEN_W-1:0]  r_len;
    logic              r_drop;    // discard the low word of the next beat

    logic [ELEM_W-1:0] w_lo;
    logic [ELEM_W-1:0] w_hi;

    assign w_lo = i_beat[ELEM_W-1:0];
    assign w_hi = i_beat[2*ELEM_W-1:ELEM_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_LANES; i++) r_lane[i] <= '0;
            r_wptr <= '0;
            r_len  <= '0;
            r_drop <= 1'b0;
        end else if (i_clear) begin
            for (int i = 0; i < N_LANES; i++) r_lane[i] <= '0;
            r_wptr <= '0;
            r_len  <= i_len;
            r_drop <= i_off;
        end else if (i_beat_valid) begin
            for (int i = 0; i < N_LANES; i++) begin
                if (LEN_W'(i) < r_len) begin
                    if (r_drop) begin
                        if (LEN_W'(i) == r_wptr) r_lane[i] <= w_hi;
                    end else begin
                        if (LEN_W'(i) == r_wptr)
                            r_lane[i] <= w_lo;
                        else if (LEN_W'(i) == r_wptr + LEN_W'(1))
                            r_lane[i] <= w_hi;
                    end
                end
            end
            r_wptr <= r_drop ? r_wptr + LEN_W'(1) : r_wptr + LEN_W'(2);
            r_drop <= 1'b0;
        end
    end

    always_comb begin
        o_lanes = '0;
        for (int i = 0; i < N_LANES; i++) o_lanes[i*ELEM_W +: ELEM_W] = r_lane[i];
    end

endmodule

// File: rtl/matrix_row_fetch.sv
// ---------------------------------------------------------------------------
// matrix_row_fetch
//   Streams rows of an int32 matrix from the 64-bit memory read port into
//   LANES-wide row vectors for the systolic array. Each row is fetched with
//   back-to-back beat reads, assembled by row_pack and presented with
//   valid/ready. Row bases only need 4-byte alignment.
//
//   Handshake: row_valid rises when a row is complete and stays high, with
//   row_data/row_idx frozen, until the cycle where row_valid & row_ready;
//   that cycle is the transfer. row_ready while row_valid is low is ignored.
//
//   Optional feature (macro ACC_FETCH_PERF_EN): adds perf_stall_cycles, a
//   saturating count of cycles with row_valid & !row_ready, cleared on reset
//   and on each accepted start.
//
//   Ports
//     clk, rst        : clock, synchronous active-high reset
//     start           : 1-cycle pulse, accepted only when idle
//     cfg_base        : byte address of row 0 (bits [1:0] zero)
//     cfg_stride      : row pitch in 32-bit elements
//     cfg_rows        : number of rows
//     cfg_len         : elements per row, values above LANES saturate
//     mem_ren/raddr   : one 64-bit read per cycle, 8-byte-aligned address
//     mem_rdata       : read data, one cycle after mem_ren
//     row_valid/ready : row handshake
//     row_data/idx    : presented row and its index
//     busy            : job in progress (from the cycle after start)
//     done            : 1-cycle pulse after the last row is taken
//     dbg_state       : current FSM state
//     perf_stall_cycles (ACC_FETCH_PERF_EN only)
// ---------------------------------------------------------------------------
module matrix_row_fetch
    import acc_pkg::*;
#(
    parameter int LANES  = acc_pkg::LANES,
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         cfg_base,
    input  logic [CNT_W-1:0]          cfg_stride,
    input  logic [CNT_W-1:0]          cfg_rows,
    input  logic [LEN_W-1:0]          cfg_len,
    output logic                      mem_ren,
    output logic [ADDR_W-1:0]         mem_raddr,
    input  logic [BEAT_W-1:0]         mem_rdata,
    output logic                      row_valid,
    input  logic                      row_ready,
    output logic [ELEM_W*LANES-1:0]   row_data,
    output logic [CNT_W-1:0]          row_idx,
    output logic                      busy,
    output logic                      done,
    output fetch_state_t              dbg_state
`ifdef ACC_FETCH_PERF_EN
    ,
    output logic [31:0]               perf_stall_cycles
`endif
);

    fetch_state_t       r_state;
    fetch_state_t       w_next_state;

    logic [CNT_W-1:0]   r_stride;
    logic [CNT_W-1:0]   r_rows;
    logic [LEN_W-1:0]   r_len;
    logic [CNT_W-1:0]   r_row_idx;
    logic [ADDR_W-1:0]  r_row_addr;    // byte address of the current row
    logic [ADDR_W-1:0]  r_beat_addr;   // address of the next beat to issue
    logic [LEN_W-1:0]   r_beats_left;  // beats still to issue for this row
    logic               r_rd_valid;    // mem_rdata carries a beat this cycle

    logic               w_start_ok;
    logic               w_hs;
    logic               w_last_row;
    logic               w_next_row;
    logic [LEN_W-1:0]   w_len_sat;
    logic [ADDR_W-1:0]  w_next_ra;
    logic [ADDR_W-1:0]  w_setup_addr;
    logic [LEN_W-1:0]   w_setup_len;
    logic [LEN_W-1:0]   w_setup_beats;

    assign w_start_ok = start && (r_state == IDLE);
    assign w_hs       = (r_state == OUT) && row_ready;
    assign w_last_row = (r_row_idx == r_rows - CNT_W'(1));
    assign w_next_row = w_hs && !w_last_row;
    assign w_len_sat  = (cfg_len > LEN_W'(LANES)) ? LEN_W'(LANES) : cfg_len;

    // Row pitch in bytes added in full address width, so it wraps mod 2^ADDR_W.
    assign w_next_ra  = r_row_addr + ADDR_W'({r_stride, 2'b00});

    // Parameters of the row about to be fetched: the first row when a start
    // is accepted, otherwise the row after the one just handed over.
    assign w_setup_addr  = (r_state == IDLE) ? cfg_base  : w_next_ra;
    assign w_setup_len   = (r_state == IDLE) ? w_len_sat : r_len;
    assign w_setup_beats = beats_for(w_setup_addr[2], w_setup_len);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        mem_ren      = 1'b0;
        row_valid    = 1'b0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    if ((cfg_rows == '0) || (cfg_len == '0)) w_next_state = FIN;
                    else                                     w_next_state = REQ;
                end
            end
            REQ: begin
                mem_ren = 1'b1;
                if (r_beats_left == LEN_W'(1)) w_next_state = DRAIN;
            end
            DRAIN: begin
                // last beat's data lands this cycle
                w_next_state = OUT;
            end
            OUT: begin
                row_valid = 1'b1;
                if (row_ready) w_next_state = w_last_row ? FIN : REQ;
            end
            FIN: begin
                done         = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                busy         = 1'b0;
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stride     <= '0;
            r_rows       <= '0;
            r_len        <= '0;
            r_row_idx    <= '0;
            r_row_addr   <= '0;
            r_beat_addr  <= '0;
            r_beats_left <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            r_rd_valid <= mem_ren;
            if (w_start_ok) begin
                r_stride     <= cfg_stride;
                r_rows       <= cfg_rows;
                r_len        <= w_len_sat;
                r_row_idx    <= '0;
                r_row_addr   <= w_setup_addr;
                r_beat_addr  <= {w_setup_addr[ADDR_W-1:3], 3'b000};
                r_beats_left <= w_setup_beats;
            end else if (w_next_row) begin
                r_row_idx    <= r_row_idx + CNT_W'(1);
                r_row_addr   <= w_setup_addr;
                r_beat_addr  <= {w_setup_addr[ADDR_W-1:3], 3'b000};
                r_beats_left <= w_setup_beats;
            end else if (r_state == REQ) begin
                r_beat_addr  <= r_beat_addr + ADDR_W'(8);
                r_beats_left <= r_beats_left - LEN_W'(1);
            end
        end
    end

    row_pack #(
        .N_LANES      (LANES)
    ) u_row_pack (
        .clk          (clk),
        .rst          (rst),
        .i_clear      (w_start_ok || w_next_row),
        .i_off        (w_setup_addr[2]),
        .i_len        (w_setup_len),
        .i_beat_valid (r_rd_valid),
        .i_beat       (mem_rdata),
        .o_lanes      (row_data)
    );

    assign mem_raddr = r_beat_addr;
    assign row_idx   = r_row_idx;
    assign dbg_state = r_state;

`ifdef ACC_FETCH_PERF_EN
    logic [31:0] r_perf;

    always_ff @(posedge clk) begin
        if (rst)
            r_perf <= '0;
        else if (w_start_ok)
            r_perf <= '0;
        else if (row_valid && !row_ready && (r_perf != 32'hFFFF_FFFF))
            r_perf <= r_perf + 32'd1;
    end

    assign perf_stall_cycles = r_perf;
`else
    // Stall counter not built.
`endif

endmodule

// File: tb/tb_matrix_row_fetch.sv
module tb_matrix_row_fetch;
  import acc_pkg::*;

  localparam int LANES_T = 16;
  localparam int AW = 64;
  localparam int CW = 32;
  localparam int DW = 32 * LANES_T;
  localparam int EW = CW + DW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic          start;
  logic [AW-1:0] cfg_base;
  logic [CW-1:0] cfg_stride;
  logic [CW-1:0] cfg_rows;
  logic [4:0]    cfg_len;
  logic          mem_ren;
  logic [AW-1:0] mem_raddr;
  logic [63:0]   mem_rdata;
  logic          row_valid;
  logic          row_ready;
  logic [DW-1:0] row_data;
  logic [CW-1:0] row_idx;
  logic          busy;
  logic          done;
  fetch_state_t  dbg_state;
`ifdef ACC_FETCH_PERF_EN
  logic [31:0]   perf_stall_cycles;
`endif

  matrix_row_fetch #(.LANES(LANES_T), .ADDR_W(AW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_base  (cfg_base),
    .cfg_stride(cfg_stride),
    .cfg_rows  (cfg_rows),
    .cfg_len   (cfg_len),
    .mem_ren   (mem_ren),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .row_valid (row_valid),
    .row_ready (row_ready),
    .row_data  (row_data),
    .row_idx   (row_idx),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state)
`ifdef ACC_FETCH_PERF_EN
    ,
    .perf_stall_cycles(perf_stall_cycles)
`endif
  );

  // ---------------- memory model ----------------
  // word at byte address a = (a - 0x80001000) / 4
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    logic [63:0] d;
    d = a - 64'h0000_0000_8000_1000;
    return d[33:2];
  endfunction

  // Data is only meaningful one cycle after mem_ren; junk otherwise.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= {mem_word(mem_raddr + 64'd4), mem_word(mem_raddr)};
    else         mem_rdata <= {$urandom, $urandom};
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int n_checks;
  int n_fail;

  task automatic check(input string name, input bit ok, input string info);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, info);
    end
  endtask

  // per-job observation state, cycle k counted from the start edge
  int k, ren_cnt, first_ren_k, first_valid_k, done_cnt, done_k, last_hs_k, stall;
  bit hold, busy1;
  logic [EW-1:0] held;

  task automatic clear_obs();
    k = 0; ren_cnt = 0; first_ren_k = -1; first_valid_k = -1;
    done_cnt = 0; done_k = -1; last_hs_k = -1; stall = 0;
    hold = 0; busy1 = 0; held = '0;
  endtask

  task automatic monitor();
    logic [EW-1:0] got;
    logic [EW-1:0] exp;
    k++;
    if (k == 1) busy1 = busy;
    if (mem_ren) begin
      ren_cnt++;
      if (first_ren_k < 0) first_ren_k = k;
      check("raddr_align", mem_raddr[2:0] == 3'b000,
            $sformatf("got addr %h, required low 3 bits zero", mem_raddr));
    end
    if (row_valid) begin
      got = {row_idx, row_data};
      if (first_valid_k < 0) first_valid_k = k;
      if (hold) check("row_stable", got == held, $sformatf("got %h, required %h", got, held));
      if (!row_ready) begin
        stall++;
        hold = 1;
        held = got;
      end else begin
        hold = 0;
        last_hs_k = k;
        check("row_expected", exp_q.size() != 0, $sformatf("got unexpected row idx %0d", row_idx));
        if (exp_q.size() != 0) begin
          exp = exp_q.pop_front();
          check("row_data", got == exp, $sformatf("got %h, required %h", got, exp));
        end
      end
    end else begin
      hold = 0;
    end
    if (done) begin
      done_cnt++;
      done_k = k;
    end
  endtask

  // sample at negedge, return just after the next rising edge
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] base;
    logic [31:0] stride;
    logic [31:0] rows;
    logic [4:0]  len;
    int          mode;       // 0 ready, 1 random ready, 3 hold low 5 valid cycles
    int          restart_k;  // cycle to pulse a second start (0 = none)
    int          exp_beats;
    int          exp_first;  // first row_valid cycle after start (-1 none)
  } vec_t;

  vec_t vecs[11];

  task automatic run_job(input vec_t v);
    logic [63:0] ra;
    logic [DW-1:0] row;
    int nl;
    bit fin;
    cfg_base = v.base; cfg_stride = v.stride; cfg_rows = v.rows; cfg_len = v.len;
    start = 1'b1;
    nl = (v.len > 5'd16) ? 16 : int'(v.len);
    if (nl != 0) begin
      for (int r = 0; r < int'(v.rows); r++) begin
        ra = v.base + 64'(v.stride) * 64'(r) * 64'd4;
        row = '0;
        for (int i = 0; i < nl; i++) row[i*32 +: 32] = mem_word(ra + 64'(4 * i));
        exp_q.push_back({CW'(r), row});
      end
    end
    tick();
    start = 1'b0;
    clear_obs();
    fin = 0;
    for (int c = 0; c < 3000 && !fin; c++) begin
      case (v.mode)
        0: row_ready = 1'b1;
        1: row_ready = 1'($urandom_range(0, 1));
        default: row_ready = (stall >= 5);
      endcase
      if (v.restart_k != 0 && k == v.restart_k) begin
        start = 1'b1; cfg_base = 64'h9000_0000; cfg_stride = 32'd3;
        cfg_rows = 32'd5; cfg_len = 5'd16;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done_cnt != 0) fin = 1;
    end
    start = 1'b0;
    row_ready = 1'b0;
    check("job_timeout", fin, $sformatf("got no done within budget (base %h)", v.base));
    check("idle_after_done", fin && !busy && !done,
          $sformatf("got busy=%0b done=%0b, required 0 0", busy, done));
    check("beat_count", ren_cnt == v.exp_beats, $sformatf("got %0d, required %0d", ren_cnt, v.exp_beats));
    check("first_valid", first_valid_k == v.exp_first,
          $sformatf("got cycle %0d, required %0d", first_valid_k, v.exp_first));
    check("done_once", done_cnt == 1, $sformatf("got %0d pulses, required 1", done_cnt));
    check("rows_left", exp_q.size() == 0, $sformatf("got %0d undelivered, required 0", exp_q.size()));
    if (v.exp_beats > 0) begin
      check("first_ren", first_ren_k == 1, $sformatf("got cycle %0d, required 1", first_ren_k));
      check("busy_after_start", busy1, $sformatf("got %0b, required 1", busy1));
      check("done_timing", done_k == last_hs_k + 1,
            $sformatf("got done cycle %0d, required %0d", done_k, last_hs_k + 1));
    end else begin
      check("empty_done", done_k == 1, $sformatf("got done cycle %0d, required 1", done_k));
    end
`ifdef ACC_FETCH_PERF_EN
    check("perf_stall", perf_stall_cycles == 32'(stall),
          $sformatf("got %0d, required %0d", perf_stall_cycles, stall));
`endif
    exp_q.delete();
  endtask

  // ---------------- main ----------------
  initial begin
    n_checks = 0; n_fail = 0;
    rst = 1'b1; start = 1'b0; row_ready = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_rows = '0; cfg_len = '0;
    clear_obs();

    vecs[0]  = '{64'h8000_1000, 32'd4,  32'd2, 5'd4,  0, 0, 4,  4};
    vecs[1]  = '{64'h8000_1004, 32'd4,  32'd1, 5'd3,  0, 0, 2,  4};
    vecs[2]  = '{64'h8000_1000, 32'd16, 32'd3, 5'd16, 1, 0, 24, 10};
    vecs[3]  = '{64'h8000_1000, 32'd5,  32'd3, 5'd5,  1, 0, 9,  5};
    vecs[4]  = '{64'h8000_1004, 32'd17, 32'd2, 5'd20, 0, 0, 17, 11};
    vecs[5]  = '{64'h8000_1000, 32'd4,  32'd0, 5'd4,  0, 0, 0,  -1};
    vecs[6]  = '{64'h8000_1000, 32'd4,  32'd2, 5'd0,  0, 0, 0,  -1};
    vecs[7]  = '{64'h8000_100C, 32'd1,  32'd4, 5'd1,  1, 0, 4,  3};
    vecs[8]  = '{64'hFFFF_FFFF_FFFF_FFF8, 32'd2, 32'd2, 5'd2, 0, 0, 2, 3};
    vecs[9]  = '{64'h8000_2004, 32'd0,  32'd1, 5'd16, 3, 0, 9,  11};
    vecs[10] = '{64'h8000_1000, 32'd4,  32'd3, 5'd4,  1, 2, 6,  4};

    repeat (3) tick();
    check("rst_mem_ren", mem_ren == 1'b0, $sformatf("got %0b, required 0", mem_ren));
    check("rst_mem_raddr", mem_raddr == '0, $sformatf("got %h, required 0", mem_raddr));
    check("rst_row_valid", row_valid == 1'b0, $sformatf("got %0b, required 0", row_valid));
    check("rst_row_data", row_data == '0, $sformatf("got %h, required 0", row_data));
    check("rst_row_idx", row_idx == '0, $sformatf("got %0d, required 0", row_idx));
    check("rst_busy_done", !busy && !done, $sformatf("got busy=%0b done=%0b, required 0 0", busy, done));
    rst = 1'b0;
    tick();

    for (int i = 0; i < 11; i++) run_job(vecs[i]);

    // reset in the middle of a row fetch
    exp_q.delete();
    cfg_base = 64'h8000_1000; cfg_stride = 32'd16; cfg_rows = 32'd2; cfg_len = 5'd16;
    start = 1'b1;
    tick();
    start = 1'b0;
    clear_obs();
    repeat (4) tick();
    check("pre_reset_beats", ren_cnt == 4, $sformatf("got %0d, required 4", ren_cnt));
    rst = 1'b1;
    tick();
    check("midrst_outputs", !mem_ren && !busy && !row_valid && !done,
          $sformatf("got ren=%0b busy=%0b valid=%0b done=%0b, required all 0",
                    mem_ren, busy, row_valid, done));
    rst = 1'b0;
    clear_obs();
    repeat (6) tick();
    check("midrst_quiet", ren_cnt == 0 && first_valid_k < 0 && done_cnt == 0,
          $sformatf("got ren=%0d valid_at=%0d done=%0d, required 0 -1 0", ren_cnt, first_valid_k, done_cnt));
    run_job(vecs[0]);

    // reset and start in the same cycle
    cfg_base = 64'h8000_1000; cfg_stride = 32'd4; cfg_rows = 32'd2; cfg_len = 5'd4;
    rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    check("rst_beats_start", !busy, $sformatf("got busy=%0b, required 0", busy));
    clear_obs();
    repeat (5) tick();
    check("rst_start_quiet", ren_cnt == 0 && done_cnt == 0,
          $sformatf("got ren=%0d done=%0d, required 0 0", ren_cnt, done_cnt));
    run_job(vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
